cla_arb_seq64: RTL

Shared-adder sequencer that gives up to NREQ requesters access to one 32-bit carry-lookahead adder (`CLA`), performing 64-bit add/subtract in two passes (low half, then high half with chained carry). It sits between the FPU's mantissa/exponent datapaths and the single adder instance. It arbitrates round-robin, registers operands and results, and returns results over a valid/ready channel.

---
 rtl/cla_arb_seq64_pkg.sv | 14 +
 rtl/CLA.sv | 49 ++++
 rtl/cla_arb_seq64_rr_arbiter.sv | 30 +++
 rtl/cla_arb_seq64.sv | 129 ++++++++++++
 4 files changed

// File: rtl/cla_arb_seq64_pkg.sv
// Shared types and widths for the two-pass 64-bit add/subtract sequencer.
package cla_pkg;

    localparam int HALF_W = 32;
    localparam int OP_W   = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/CLA.sv
// 32-bit carry-lookahead adder: eight 4-bit groups with a lookahead carry chain between groups.
module CLA (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [7:0]  gg;
    logic [7:0]  gp;
    logic [8:0]  gc;
    logic        cb;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        gg  = '0;
        gp  = '0;
        gc  = '0;
        sum = '0;
        cb  = 1'b0;
        for (int grp = 0; grp < 8; grp++) begin
            gg[grp] = 1'b0;
            gp[grp] = 1'b1;
            for (int j = 0; j < 4; j++) begin
                gg[grp] = g[4*grp+j] | (p[4*grp+j] & gg[grp]);
                gp[grp] = gp[grp] & p[4*grp+j];
            end
        end
        gc[0] = cin;
        for (int grp = 0; grp < 8; grp++) begin
            gc[grp+1] = gg[grp] | (gp[grp] & gc[grp]);
        end
        // Bit carries only ripple inside a group; each group starts from its lookahead carry.
        for (int i = 0; i < 32; i++) begin
            if ((i % 4) == 0) begin
                cb = gc[i/4];
            end
            sum[i] = p[i] ^ cb;
            cb     = g[i] | (p[i] & cb);
        end
        cout = gc[8];
    end

endmodule

// File: rtl/cla_arb_seq64_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr (wrapping) wins.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/cla_arb_seq64.sv
// Shares one 32-bit CLA among NREQ requesters, doing 64-bit add/sub as a low pass then a high pass.
module cla_arb_seq64
    import cla_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OP_W-1:0] req_a,
    input  logic [NREQ*OP_W-1:0] req_b,
    input  logic [NREQ-1:0]      req_sub,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [OP_W-1:0]      rsp_sum,
    output logic                 rsp_cout,
    output logic                 rsp_ovf
);

    state_t              state;
    logic [IDW-1:0]      ptr;
    logic [IDW-1:0]      gidx;
    logic [IDW-1:0]      ptr_nxt;
    logic [NREQ-1:0]     grant;

    logic [OP_W-1:0]     a_q;
    logic [OP_W-1:0]     b_q;
    logic                sub_q;
    logic                c32;
    logic [OP_W-1:0]     bb;

    logic [HALF_W-1:0]   add_a;
    logic [HALF_W-1:0]   add_b;
    logic [HALF_W-1:0]   add_s;
    logic                add_cin;
    logic                add_cout;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IDW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (gidx)
    );

    // Subtract is A + ~B + 1; the +1 enters as the low-pass carry-in.
    assign bb = sub_q ? ~b_q : b_q;

    always_comb begin
        if (state == HI) begin
            add_a   = a_q[OP_W-1:HALF_W];
            add_b   = bb[OP_W-1:HALF_W];
            add_cin = c32;
        end else begin
            add_a   = a_q[HALF_W-1:0];
            add_b   = bb[HALF_W-1:0];
            add_cin = sub_q;
        end
    end

    CLA u_cla (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_s),
        .cout (add_cout)
    );

    // rst_n gating keeps req_ready low while reset is held even though state already reads IDLE.
    assign req_ready = (state == IDLE && rst_n) ? grant : '0;
    assign rsp_valid = (state == DONE);
    assign ptr_nxt   = (int'(gidx) == NREQ - 1) ? '0 : gidx + IDW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        rsp_id <= gidx;
                        ptr    <= ptr_nxt;
                        state  <= LO;
                    end
                end
                LO: begin
                    rsp_sum[HALF_W-1:0] <= add_s;
                    state               <= HI;
                end
                HI: begin
                    rsp_sum[OP_W-1:HALF_W] <= add_s;
                    rsp_cout               <= add_cout;
                    rsp_ovf                <= (a_q[OP_W-1] == bb[OP_W-1]) &&
                                              (add_s[HALF_W-1] != a_q[OP_W-1]);
                    state                  <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand and inter-pass carry registers are only read after being loaded, so they skip reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && rst_n && (|req_valid)) begin
            a_q   <= req_a[int'(gidx)*OP_W +: OP_W];
            b_q   <= req_b[int'(gidx)*OP_W +: OP_W];
            sub_q <= req_sub[gidx];
        end
        if (state == LO) begin
            c32 <= add_cout;
        end
    end

endmodule
